surfturf_cmd_scheduler: RTL and testbench



---
 rtl/surfturf_sched_pkg.sv | 27 ++
 rtl/surfturf_sched_arb.sv | 22 ++
 rtl/surfturf_cmd_scheduler.sv | 101 ++++++++++
 tb/tb_surfturf_cmd_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/surfturf_sched_pkg.sv
// Shared frame-format constants for the SURF command scheduler.
// Payload widths fall back to the current rackbus widths when the rackbus header is not present.
`ifndef RACKBUS_RUNCMD_BITS
`define RACKBUS_RUNCMD_BITS 2
`endif
`ifndef RACKBUS_TRIG_BITS
`define RACKBUS_TRIG_BITS 15
`endif

package surfturf_sched_pkg;
    localparam int FRAME_W       = 18;
    localparam int TYPE_LSB      = 16;
    localparam int MARK_FLAG_BIT = 10;
    localparam int MARK_LSB      = 8;

    typedef enum logic [1:0] {
        FT_IDLE   = 2'b00,
        FT_RUNCMD = 2'b01,
        FT_TRIG   = 2'b10,
        FT_FW     = 2'b11
    } frame_type_e;

    // Bit positions inside the one-hot grant vector.
    localparam int GNT_RUNCMD = 0;
    localparam int GNT_TRIG   = 1;
    localparam int GNT_FW     = 2;
endpackage

// File: rtl/surfturf_sched_arb.sv
// Per-frame grant: runcmd > (starved fw) > trig > fw; one-hot, or all-zero for IDLE.
module surfturf_sched_arb
    import surfturf_sched_pkg::*;
(
    input  logic       runcmd_valid,
    input  logic       trig_valid,
    input  logic       fw_pending,
    input  logic       starved,
    output logic [2:0] grant
);
    always_comb begin
        grant = '0;
        if (runcmd_valid)
            grant[GNT_RUNCMD] = 1'b1;
        else if (starved && fw_pending)
            grant[GNT_FW] = 1'b1;
        else if (trig_valid)
            grant[GNT_TRIG] = 1'b1;
        else if (fw_pending)
            grant[GNT_FW] = 1'b1;
    end
endmodule

// File: rtl/surfturf_cmd_scheduler.sv
// Multiplexes runcmd, trig and fwupdate streams onto fixed-length rackbus command frames.
// Handshake: a transfer happens on an edge where tvalid & tready are both high; tready rises only on decide cycles and only with its tvalid high.
module surfturf_cmd_scheduler
    import surfturf_sched_pkg::*;
#(
    parameter int FRAME_LEN     = 8,
    parameter int FW_STARVE_MAX = 4,
    parameter int RUNCMD_BITS   = `RACKBUS_RUNCMD_BITS,
    parameter int TRIG_BITS     = `RACKBUS_TRIG_BITS
) (
    input  logic                   sysclk_i,
    input  logic                   sysclk_rst_i,
    input  logic                   en_i,
    input  logic [RUNCMD_BITS-1:0] runcmd_tdata,
    input  logic                   runcmd_tvalid,
    output logic                   runcmd_tready,
    input  logic [TRIG_BITS-1:0]   trig_tdata,
    input  logic                   trig_tvalid,
    output logic                   trig_tready,
    input  logic [7:0]             fw_tdata,
    input  logic                   fw_tvalid,
    output logic                   fw_tready,
    input  logic [1:0]             fw_mark_i,
    output logic                   fw_marked_o,
    output logic [FRAME_W-1:0]     frame_o,
    output logic                   frame_start_o
);
    localparam int             CNT_W      = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [3:0]     STARVE_MAX = 4'(FW_STARVE_MAX);

    logic [CNT_W-1:0]   cnt;
    logic [3:0]         starve_cnt;
    logic               decide;
    logic               fw_pending;
    logic               starved;
    logic [2:0]         grant;
    logic [FRAME_W-1:0] frame_next;

    // Reset is folded in so no tready can leak out while the block is held in reset.
    assign decide     = en_i && !sysclk_rst_i && (cnt == CNT_LAST);
    assign fw_pending = fw_tvalid || (fw_mark_i != 2'b00);
    assign starved    = (starve_cnt == STARVE_MAX);

    surfturf_sched_arb u_arb (
        .runcmd_valid (runcmd_tvalid),
        .trig_valid   (trig_tvalid),
        .fw_pending   (fw_pending),
        .starved      (starved),
        .grant        (grant)
    );

    assign runcmd_tready = decide && grant[GNT_RUNCMD];
    assign trig_tready   = decide && grant[GNT_TRIG];
    assign fw_tready     = decide && grant[GNT_FW] && fw_tvalid;
    // Data bytes go first; a mark frame is only sent when no byte is waiting.
    assign fw_marked_o   = decide && grant[GNT_FW] && !fw_tvalid;

    always_comb begin
        frame_next = '0;
        if (grant[GNT_RUNCMD]) begin
            frame_next[TYPE_LSB +: 2]     = FT_RUNCMD;
            frame_next[RUNCMD_BITS-1:0]   = runcmd_tdata;
        end else if (grant[GNT_TRIG]) begin
            frame_next[TYPE_LSB +: 2]     = FT_TRIG;
            frame_next[TRIG_BITS-1:0]     = trig_tdata;
        end else if (grant[GNT_FW]) begin
            frame_next[TYPE_LSB +: 2]     = FT_FW;
            if (fw_tvalid) begin
                frame_next[7:0]           = fw_tdata;
            end else begin
                frame_next[MARK_FLAG_BIT] = 1'b1;
                frame_next[MARK_LSB +: 2] = fw_mark_i;
            end
        end
    end

    always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
        if (sysclk_rst_i) begin
            cnt           <= CNT_LAST;
            starve_cnt    <= '0;
            frame_o       <= '0;
            frame_start_o <= 1'b0;
        end else if (!en_i) begin
            cnt           <= CNT_LAST;
            frame_o       <= '0;
            frame_start_o <= 1'b0;
        end else if (decide) begin
            cnt           <= '0;
            frame_o       <= frame_next;
            frame_start_o <= 1'b1;
            if (grant[GNT_FW] || !fw_pending)
                starve_cnt <= '0;
            else if (!starved)
                starve_cnt <= starve_cnt + 4'd1;
        end else begin
            cnt           <= cnt + CNT_W'(1);
            frame_start_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_surfturf_cmd_scheduler.sv
// Directed plus randomized bench for surfturf_cmd_scheduler against a frame-level reference model.
module tb_surfturf_cmd_scheduler;
    localparam int FRAME_LEN     = 8;
    localparam int FW_STARVE_MAX = 4;
    localparam int RUNCMD_BITS   = 2;
    localparam int TRIG_BITS     = 15;

    logic                   sysclk = 1'b0;
    logic                   rst;
    logic                   en;
    logic [RUNCMD_BITS-1:0] runcmd_tdata;
    logic                   runcmd_tvalid;
    logic                   runcmd_tready;
    logic [TRIG_BITS-1:0]   trig_tdata;
    logic                   trig_tvalid;
    logic                   trig_tready;
    logic [7:0]             fw_tdata;
    logic                   fw_tvalid;
    logic                   fw_tready;
    logic [1:0]             fw_mark;
    logic                   fw_marked;
    logic [17:0]            frame;
    logic                   frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position inside the frame, lost-arbitration count, current frame word.
    int          m_pos;
    int          m_starve;
    logic [17:0] m_frame;
    logic        m_start;

    surfturf_cmd_scheduler #(
        .FRAME_LEN     (FRAME_LEN),
        .FW_STARVE_MAX (FW_STARVE_MAX),
        .RUNCMD_BITS   (RUNCMD_BITS),
        .TRIG_BITS     (TRIG_BITS)
    ) dut (
        .sysclk_i      (sysclk),
        .sysclk_rst_i  (rst),
        .en_i          (en),
        .runcmd_tdata  (runcmd_tdata),
        .runcmd_tvalid (runcmd_tvalid),
        .runcmd_tready (runcmd_tready),
        .trig_tdata    (trig_tdata),
        .trig_tvalid   (trig_tvalid),
        .trig_tready   (trig_tready),
        .fw_tdata      (fw_tdata),
        .fw_tvalid     (fw_tvalid),
        .fw_tready     (fw_tready),
        .fw_mark_i     (fw_mark),
        .fw_marked_o   (fw_marked),
        .frame_o       (frame),
        .frame_start_o (frame_start)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos    = FRAME_LEN - 1;
        m_starve = 0;
        m_frame  = '0;
        m_start  = 1'b0;
    endtask

    // Winner codes: 0 idle, 1 runcmd, 2 trig, 3 fw.
    task automatic model_pick(output int win, output bit dec);
        bit fw_pend;
        dec     = en && !rst && (m_pos == FRAME_LEN - 1);
        fw_pend = fw_tvalid || (fw_mark != 2'b00);
        win     = 0;
        if (dec) begin
            if (runcmd_tvalid)                             win = 1;
            else if (m_starve == FW_STARVE_MAX && fw_pend) win = 3;
            else if (trig_tvalid)                          win = 2;
            else if (fw_pend)                              win = 3;
        end
    endtask

    function automatic logic [17:0] frame_for(input int win);
        logic [17:0] f;
        f = '0;
        case (win)
            1: f = (18'd1 << 16) | 18'(runcmd_tdata);
            2: f = (18'd2 << 16) | 18'(trig_tdata);
            3: if (fw_tvalid) f = (18'd3 << 16) | 18'(fw_tdata);
               else           f = (18'd3 << 16) | (18'd1 << 10) | (18'(fw_mark) << 8);
            default: f = '0;
        endcase
        return f;
    endfunction

    // One clock: check all outputs at the falling edge, then advance the model over the rising edge.
    task automatic step();
        int          win;
        bit          dec;
        bit          fw_pend;
        logic [17:0] nf;
        @(negedge sysclk);
        model_pick(win, dec);
        check("frame_o",       frame,         m_frame);
        check("frame_start_o", 18'(frame_start),   18'(m_start));
        check("runcmd_tready", 18'(runcmd_tready), 18'(win == 1));
        check("trig_tready",   18'(trig_tready),   18'(win == 2));
        check("fw_tready",     18'(fw_tready),     18'(win == 3 && fw_tvalid));
        check("fw_marked_o",   18'(fw_marked),     18'(win == 3 && !fw_tvalid));
        nf      = frame_for(win);
        fw_pend = fw_tvalid || (fw_mark != 2'b00);
        @(posedge sysclk);
        if (!en) begin
            m_pos   = FRAME_LEN - 1;
            m_frame = '0;
            m_start = 1'b0;
        end else if (dec) begin
            m_pos   = 0;
            m_frame = nf;
            m_start = 1'b1;
            if (win == 3 || !fw_pend) m_starve = 0;
            else if (m_starve < FW_STARVE_MAX) m_starve = m_starve + 1;
        end else begin
            m_pos   = m_pos + 1;
            m_start = 1'b0;
        end
        #1;
    endtask

    task automatic run_frame();
        for (int i = 0; i < FRAME_LEN; i++) step();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_frame"},  frame,               18'h0);
        check({tag, "_start"},  18'(frame_start),    18'h0);
        check({tag, "_treadys"}, 18'({runcmd_tready, trig_tready, fw_tready}), 18'h0);
        check({tag, "_marked"}, 18'(fw_marked),      18'h0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0;
        runcmd_tdata = '0; runcmd_tvalid = 1'b0;
        trig_tdata = '0; trig_tvalid = 1'b0;
        fw_tdata = '0; fw_tvalid = 1'b0; fw_mark = 2'b00;
        model_reset();
        #1;
        check_quiet("reset");
        repeat (2) @(posedge sysclk);
        #1;
        rst = 1'b0; en = 1'b1;

        // Idle: three empty frames, frame_start every FRAME_LEN cycles.
        repeat (3) run_frame();
        check("idle_frame", frame, 18'h0);

        // runcmd outranks trig; trig follows once runcmd drops.
        runcmd_tdata = 2'b10; runcmd_tvalid = 1'b1;
        trig_tdata = 15'h1234; trig_tvalid = 1'b1;
        run_frame();
        check("runcmd_frame", frame, 18'h10002);
        runcmd_tvalid = 1'b0;
        run_frame();
        check("trig_after_runcmd", frame, 18'h21234);

        // Starvation: fw waits four frames behind trig, then wins once.
        fw_tdata = 8'hA5; fw_tvalid = 1'b1;
        for (int f = 1; f <= 6; f++) begin
            run_frame();
            check($sformatf("starve_frame%0d", f), frame, (f == 5) ? 18'h300A5 : 18'h21234);
        end
        fw_tvalid = 1'b0; trig_tvalid = 1'b0;

        // Mark frame with both bits.
        fw_mark = 2'b11;
        run_frame();
        check("mark11_frame", frame, 18'h30700);
        fw_mark = 2'b00;

        // Data byte goes ahead of a pending mark.
        fw_tdata = 8'h5A; fw_tvalid = 1'b1; fw_mark = 2'b01;
        run_frame();
        check("data_before_mark", frame, 18'h3005A);
        fw_tvalid = 1'b0;
        run_frame();
        check("mark01_frame", frame, 18'h30500);
        fw_mark = 2'b00;

        // Asynchronous reset mid-frame with a frame on the bus.
        trig_tdata = 15'h0777; trig_tvalid = 1'b1;
        run_frame();
        repeat (3) step();
        #2 rst = 1'b1;
        #1 check_quiet("midframe_reset");
        @(posedge sysclk);
        #1 rst = 1'b0;
        model_reset();
        run_frame();
        check("trig_after_reset", frame, 18'h20777);

        // Enable dropped mid-frame, then restored: first enabled cycle decides.
        repeat (3) step();
        en = 1'b0;
        step();
        check("en_drop_idle", frame, 18'h0);
        repeat (2) step();
        en = 1'b1;
        step();
        check("reenable_start", 18'(frame_start), 18'h1);
        check("reenable_frame", frame, 18'h20777);
        trig_tvalid = 1'b0;

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            en            = ($urandom_range(0, 39) != 0);
            runcmd_tvalid = ($urandom_range(0, 9) == 0);
            runcmd_tdata  = RUNCMD_BITS'($urandom);
            trig_tvalid   = ($urandom_range(0, 2) == 0);
            trig_tdata    = TRIG_BITS'($urandom);
            fw_tvalid     = ($urandom_range(0, 2) == 0);
            fw_tdata      = 8'($urandom);
            fw_mark       = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
